// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states,
// ALUOp and ALUControlSignal codes, and the datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct3/funct7b5/op[5] -> ALUControlSignal mapping.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output logic [2:0]  alu_control
);

    always_comb begin
        // NOTE: assign a default first so no path through the case leaves the output unassigned (latch).
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) uses funct7b5 to pick sub; addi ignores it.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath enables, mux selects and ALU control from the state.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        ZeroFlag,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [2:0]  ALUControlSignal,
    output logic        IllegalInstr,
    output logic        InstrRetired
);

    state_t  state;
    alu_op_t alu_op;
    logic    mem_ready;

    assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;
    assign ImmSrc    = imm_src_of(op);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_BEQ:       state <= S_BEQ;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR,
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        InstrRetired = 1'b0;
        alu_op       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                MemWrite     = 1'b1;
                InstrRetired = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA      = SRCA_RS1;
                alu_op       = ALUOP_SUB;
                PCWrite      = ZeroFlag;
                InstrRetired = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_TRAP:     IllegalInstr = 1'b1;
            default:    IllegalInstr = 1'b1;
        endcase
        // Reset suppresses every write strobe immediately, before the state register updates.
        if (rst) begin
            PCWrite      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            IllegalInstr = 1'b0;
            InstrRetired = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControlSignal)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected output bundles are queued as
// each cycle's stimulus is driven and compared at the following negedge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, ZeroFlag, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr, InstrRetired;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControlSignal;

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .ZeroFlag(ZeroFlag), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControlSignal(ALUControlSignal), .IllegalInstr(IllegalInstr),
        .InstrRetired(InstrRetired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [17:0] sb_q[$];
    logic [17:0] obs;

    // Bundle: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc RegWrite ALUCtl Illegal Retired
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                  RegWrite, ALUControlSignal, IllegalInstr, InstrRetired};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] v(input bit pcw, input bit adr, input bit mw, input bit irw,
                                      input bit [1:0] rs, input bit [1:0] sa, input bit [1:0] sb,
                                      input bit [1:0] imm, input bit rw, input bit [2:0] alu,
                                      input bit ill, input bit ret);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill, ret};
    endfunction

    function automatic logic [17:0] fetch_v(input bit mr, input bit [1:0] imm);
        return v(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, imm, 1'b0, 3'b000, 1'b0, 1'b0);
    endfunction

    function automatic logic [17:0] decode_v(input bit [1:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0, 3'b000, 1'b0, 1'b0);
    endfunction

    function automatic logic [17:0] aluwb_v(input bit [1:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b1, 3'b000, 1'b0, 1'b1);
    endfunction

    function automatic logic [17:0] exec_v(input bit [1:0] sb, input bit [2:0] alu);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, 2'b00, 1'b0, alu, 1'b0, 1'b0);
    endfunction

    // Write-enable bits that must be low while rst is asserted.
    logic [17:0] en_mask;
    assign en_mask = v(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1);

    task automatic load(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic step(input string tag, input bit mr, input bit zf, input logic [17:0] e);
        MemReady = mr;
        ZeroFlag = zf;
        sb_q.push_back(e);
        @(negedge clk);
        check(tag, obs, sb_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check(tag, obs & en_mask, 18'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input bit [1:0] sb, input bit [2:0] alu);
        load(o, f3, f7);
        step({tag, "_fetch"}, 1'b1, 1'b0, fetch_v(1'b1, 2'b00));
        step({tag, "_decode"}, 1'b1, 1'b0, decode_v(2'b00));
        step({tag, "_exec"}, 1'b1, 1'b0, exec_v(sb, alu));
        step({tag, "_aluwb"}, 1'b1, 1'b0, aluwb_v(2'b00));
    endtask

    initial begin
        rst = 1'b1; MemReady = 1'b1; ZeroFlag = 1'b0;
        load(7'b0110011, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        reset_cycle("reset_1");
        reset_cycle("reset_2");
        rst = 1'b0;

        // R-type sub, slti, addi with funct7b5=1, R-type and/or
        alu_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
        alu_instr("i_slti", 7'b0010011, 3'b010, 1'b0, 2'b01, 3'b101);
        alu_instr("i_addi_f7", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
        alu_instr("r_and", 7'b0110011, 3'b111, 1'b0, 2'b00, 3'b010);
        alu_instr("r_or", 7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);

        // beq taken / not taken; the not-taken case also stalls one cycle in FETCH
        load(7'b1100011, 3'b000, 1'b0);
        step("beq1_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b10));
        step("beq1_decode", 1'b1, 1'b0, decode_v(2'b10));
        step("beq1_beq", 1'b1, 1'b1, v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b001, 1'b0, 1'b1));
        step("beq0_fetch_wait", 1'b0, 1'b0, fetch_v(1'b0, 2'b10));
        step("beq0_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b10));
        step("beq0_decode", 1'b1, 1'b0, decode_v(2'b10));
        step("beq0_beq", 1'b1, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b001, 1'b0, 1'b1));

        // jal
        load(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b11));
        step("jal_decode", 1'b1, 1'b0, decode_v(2'b11));
        step("jal_jal", 1'b1, 1'b0, v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0));
        step("jal_aluwb", 1'b1, 1'b0, aluwb_v(2'b11));

        // lw with two wait cycles in MEMREAD: 7 cycles total
        load(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b00));
        step("lw_decode", 1'b1, 1'b0, decode_v(2'b00));
        step("lw_memadr", 1'b0, 1'b0, exec_v(2'b01, 3'b000));
        for (int i = 0; i < 3; i++)
            step($sformatf("lw_memread%0d", i), (i == 2), 1'b0,
                 v(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0));
        step("lw_memwb", 1'b1, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1));

        // sw with one wait cycle: MemWrite high for two cycles, retire on the second
        load(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b01));
        step("sw_decode", 1'b1, 1'b0, decode_v(2'b01));
        step("sw_memadr", 1'b1, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0));
        step("sw_memwrite_wait", 1'b0, 1'b0, v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0));
        step("sw_memwrite_done", 1'b1, 1'b0, v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1));

        // Illegal opcode: sticky TRAP until reset
        load(7'b0000000, 3'b000, 1'b0);
        step("ill_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b00));
        step("ill_decode", 1'b1, 1'b0, decode_v(2'b00));
        for (int i = 0; i < 12; i++)
            step($sformatf("trap%0d", i), i[0], 1'b1,
                 v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0));
        reset_cycle("trap_reset");
        rst = 1'b0;
        step("trap_exit_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b00));

        // Reset while stalled in MEMWRITE: strobe drops, FSM back in FETCH
        load(7'b0100011, 3'b010, 1'b0);
        step("swr_decode", 1'b1, 1'b0, decode_v(2'b01));
        step("swr_memadr", 1'b1, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0));
        step("swr_memwrite", 1'b0, 1'b0, v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0));
        MemReady = 1'b0;
        reset_cycle("swr_reset");
        rst = 1'b0;
        step("swr_after_fetch", 1'b1, 1'b0, fetch_v(1'b1, 2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control unit for the single-core RISC-V datapath. It is the producer side of the ALU control/flag interface: it drives ALUControlSignal and consumes ZeroFlag.
- A Moore FSM sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- It drives all datapath enables and muxes. It also supports a memory-ready handshake for slow memory.

Parameters:
MEM_WAIT_EN  1  1: FETCH/MEMREAD/MEMWRITE hold until MemReady=1; 0: MemReady ignored (treated as 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
op  input  7  instruction opcode (Instr[6:0])
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
ZeroFlag  input  1  ALU zero flag
MemReady  input  1  memory access complete this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  0=PC, 1=ALU result as memory address
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  output  2  00=rs2, 01=imm, 10=constant 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
RegWrite  output  1  register file write enable
ALUControlSignal  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
IllegalInstr  output  1  high while FSM is in TRAP
InstrRetired  output  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset: rst sampled at posedge forces state to FETCH. While rst=1, PCWrite, MemWrite, IRWrite, RegWrite, IllegalInstr and InstrRetired are 0. Reset mid-instruction abandons it with no further writes.
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are asserted only when MemReady=1; advance to DECODE then, else hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - lw/sw -> MEMADR
  - R -> EXECR
  - I -> EXECI
  - beq -> BEQ
  - jal -> JAL
  - any other opcode -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held while waiting). Hold until MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=ZeroFlag (combinational, same cycle), then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB.
- TRAP: sticky, all enables 0, IllegalInstr=1. Exited only by rst.
- Unlisted outputs default to 0 in every state.
- InstrRetired=1 in the final cycle of each instruction: MEMWB, ALUWB, BEQ, and MEMWRITE when MemReady=1.
- ImmSrc is combinational from op in every state: lw/I 00, sw 01, beq 10, jal 11, other 00.
- ALU decode:
  - ALUOp=00 -> 000 (add); ALUOp=01 -> 001 (sub).
  - ALUOp=10 by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- Latencies with no wait states: R/I 4 cycles, lw 5, sw 4, beq 3, jal 4. Each MemReady=0 cycle adds one cycle.

Decomposition:
- Package riscv_ctrl_pkg holds opcode constants, state encodings, ALUOp codes, ALUControlSignal codes (shared with alu) and the ResultSrc/ALUSrc/ImmSrc encodings.
- Sub-module alu_decoder is the combinational ALUOp/funct3/funct7b5/op -> ALUControlSignal mapping.
- multicycle_control contains the FSM and the output decode.

Test Plan:
- Reset: rst=1 for 2 cycles -> state FETCH, all write enables 0. Release with MemReady=1 -> IRWrite=1, PCWrite=1 and ALUSrcB=10 in the first cycle.
- R-type sub (op=0110011, funct3=000, funct7b5=1): DECODE then EXECR -> ALUControlSignal=001. ALUWB asserts RegWrite=1 and InstrRetired=1; 4 cycles total.
- I-type slti (op=0010011, funct3=010) -> EXECI drives ALUControlSignal=101, ALUSrcB=01.
- I-type addi with funct7b5=1 (op=0010011, funct3=000) -> EXECI drives ALUControlSignal=000, not 001.
- beq with ZeroFlag=1 -> PCWrite=1 in BEQ. With ZeroFlag=0 -> PCWrite=0. Both cases return to FETCH after 3 cycles.
- lw with MemReady low for 2 cycles in MEMREAD -> 2 extra MEMREAD cycles, then MEMWB with ResultSrc=01 and RegWrite=1; 7 cycles total. sw with MemReady low 1 cycle -> MemWrite high for 2 cycles.
- Illegal opcode 0000000 -> TRAP with IllegalInstr=1, held for 10+ cycles. rst then returns the FSM to FETCH. Separately, rst asserted in MEMWRITE -> MemWrite=0 at the next edge and the FSM is in FETCH.
